parity_serial_tx: RTL and testbench
===================================

// Module: parity_serial_tx
// PURPOSE
//   Transmit side of the nibble parity link. Accepts a DATA_W-bit word over a
//   valid/ready handshake and computes its parity bit. Shifts out a framed
//   serial stream: start, data LSB-first, parity, stop. The far-end even/odd
//   detector checks the stream. One frame in flight; busy until stop completes.
// PARAMETERS
//   DATA_W      4   payload bits per frame (>=1)
//   BAUD_DIV    4   clk cycles per serial bit-time (>=1)
//   PARITY_ODD  0   0: even parity (ones in data+parity even); 1: odd parity
// PORTS
//   clk          in   1       single clock; all state changes on rising edge
//   rst_n        in   1       synchronous reset, active-low
//   in_valid     in   1       in_data is offered this cycle
//   in_data      in   DATA_W  payload word, sampled on handshake
//   in_ready     out  1       block can accept a word this cycle
//   tx_bit       out  1       serial line, idles high
//   tx_active    out  1       high while a frame is being driven
//   parity_out   out  1       parity bit of the last accepted word
//   frame_done   out  1       1-cycle pulse in the final cycle of the stop bit
// BEHAVIOUR
//   Reset (rst_n low at edge): state IDLE, tx_bit=1, in_ready=0, tx_active=0,
//     parity_out=0, frame_done=0, counters 0. in_ready rises the first cycle
//     after rst_n is seen high. Reset mid-frame aborts the frame immediately;
//     the line returns to 1 and no frame_done pulse is issued.
//   All outputs are registered.
//   Handshake: a transfer occurs on an edge where in_valid && in_ready. in_ready
//     is 1 only in IDLE and drops the cycle after a transfer. in_valid/in_data
//     are ignored while busy; no buffering, so the word is not queued.
//   Transfer: latch in_data into a shift reg. Set parity_out = ^in_data ^ PARITY_ODD.
//   FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//     START:  tx_bit=0 for BAUD_DIV cycles; starts the cycle after the transfer.
//     DATA:   tx_bit=shreg[0]; shift right every BAUD_DIV cycles; leave after DATA_W bits.
//     PARITY: tx_bit=parity_out for BAUD_DIV cycles.
//     STOP:   tx_bit=1 for BAUD_DIV cycles; frame_done=1 in its last cycle.
//   tx_active=1 in START..STOP inclusive, else 0.
//   Frame length = (DATA_W+3)*BAUD_DIV cycles. in_ready returns the cycle after
//     STOP ends, giving a minimum of 1 idle cycle between back-to-back frames.
//   Baud counter: width max(1,$clog2(BAUD_DIV)). It counts 0..BAUD_DIV-1, wraps to
//     0 and emits a tick on wrap. BAUD_DIV=1 gives a tick every cycle.
//   Bit index: width max(1,$clog2(DATA_W)). Reset to 0 on entering DATA.
//     Leave DATA on the tick where index==DATA_W-1.
// STRUCTURE
//   Package parity_tx_pkg: typedef enum logic[2:0] tx_state_t {IDLE,START,DATA,
//     PARITY,STOP}; localparams LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
//   Sub-module bit_timer (BAUD_DIV): inputs clk, rst_n, en; output tick.
//     The counter is cleared when en=0. Top FSM drives en=tx_active.
// TESTING (DATA_W=4, BAUD_DIV=2 unless noted)
//   1 Even, in_data=4'b0001: line 0,1,0,0,0,1,1, each 2 cycles; parity_out=1;
//     frame_done at cycle 14 after the transfer.
//   2 Even, 4'b0100 -> parity 1; 4'b0011 -> parity 0; 4'b0000 -> parity 0.
//     Bench checks the received data+parity count is even.
//   3 PARITY_ODD=1, 4'b0001 -> parity_out=0; 4'b1111 -> 1.
//     The far-end detector reports odd total.
//   4 in_valid held high with 4'b1010 then 4'b0101: both frames are sent in order.
//     Exactly 1 idle cycle (tx_bit=1, in_ready=1) separates them.
//   5 in_valid pulsed with 4'b1111 during DATA of frame 4'b0001: word dropped.
//     Frame unaltered; in_ready stays 0.
//   6 rst_n low for 1 cycle in DATA: next cycle tx_bit=1, tx_active=0, in_ready=0.
//     No frame_done pulse. in_ready=1 one cycle after release.
//     BAUD_DIV=1 rerun of scenario 1 yields a 7-cycle frame.

Source files
------------

// File: rtl/parity_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : parity_tx_pkg
// Description : Shared types and constants for the nibble parity link
//               transmitter: FSM state encoding, serial line levels and a
//               counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package parity_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width that never collapses to zero bits for tiny ranges
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : parity_tx_pkg
`default_nettype wire

// File: rtl/bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : bit_timer
// Description : Bit-time divider. Counts 0..BAUD_DIV-1 while enabled and
//               pulses tick in the final cycle of each bit-time. pre_tick
//               flags that the following cycle will carry a tick if the
//               enable holds. Counter is held at zero while disabled.
// Revision    : 1.0  initial release
// ============================================================================
module bit_timer
   import parity_tx_pkg::*;
#(
   parameter int BAUD_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick,
   output logic pre_tick
);

   localparam int                CNT_W    = clog2_min1(BAUD_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear when idle or on wrap, otherwise advance
   always_comb begin
      cnt_d = cnt_q;
      if (!en || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == CNT_LAST);

   // With a single-cycle bit-time every enabled cycle is followed by a tick
   if (BAUD_DIV == 1) begin : g_pre_single
      assign pre_tick = en;
   end else begin : g_pre_multi
      assign pre_tick = en && (cnt_q == CNT_W'(BAUD_DIV - 2));
   end

endmodule : bit_timer
`default_nettype wire

// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : parity_serial_tx
// Description : Transmit side of the nibble parity link. Accepts one word on
//               a valid/ready handshake, computes its parity and shifts out
//               start, data LSB-first, parity and stop bits. All outputs are
//               registered: they are decoded from the next state so they
//               line up with the state register.
// Revision    : 1.0  initial release
// ============================================================================
module parity_serial_tx
   import parity_tx_pkg::*;
#(
   parameter int DATA_W     = 4,
   parameter int BAUD_DIV   = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_active,
   output logic              parity_out,
   output logic              frame_done
);

   localparam int               IDX_W    = clog2_min1(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic             ODD_BIT  = (PARITY_ODD != 0);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              parity_q, parity_d;
   logic              tx_bit_q, tx_bit_d;
   logic              tx_active_q, tx_active_d;
   logic              in_ready_q, in_ready_d;
   logic              frame_done_q, frame_done_d;
   logic              tick;
   logic              pre_tick;
   logic              xfer;

   // in_ready is only ever high in IDLE, so a transfer implies IDLE
   assign xfer = in_valid && in_ready_q;

   bit_timer #(
      .BAUD_DIV (BAUD_DIV)
   ) u_bit_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (tx_active_q),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: each framed phase lasts until its bit-time tick
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (xfer) state_d = START;
         START:   if (tick) state_d = DATA;
         DATA:    if (tick && (idx_q == IDX_LAST)) state_d = PARITY;
         PARITY:  if (tick) state_d = STOP;
         STOP:    if (tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: load word and parity on transfer, shift once per data bit-time
   always_comb begin
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      parity_d = parity_q;
      if (xfer) begin
         shreg_d  = in_data;
         parity_d = (^in_data) ^ ODD_BIT;
      end
      if ((state_q == START) && tick) begin
         idx_d = '0;
      end
      if ((state_q == DATA) && tick) begin
         shreg_d = shreg_q >> 1;
         idx_d   = idx_q + 1'b1;
      end
   end

   // Output decode from the next state so the registered outputs track state_q
   always_comb begin
      tx_bit_d     = LINE_IDLE;
      frame_done_d = 1'b0;
      tx_active_d  = (state_d != IDLE);
      in_ready_d   = (state_d == IDLE);
      case (state_d)
         START:   tx_bit_d = START_BIT;
         DATA:    tx_bit_d = shreg_d[0];
         PARITY:  tx_bit_d = parity_d;
         STOP: begin
            tx_bit_d = STOP_BIT;
            // Next cycle is the last stop cycle: either the timer is one
            // short of wrapping, or every bit-time is a single cycle
            frame_done_d = (state_q == STOP) ? pre_tick : (BAUD_DIV == 1);
         end
         default: tx_bit_d = LINE_IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q      <= '0;
         idx_q        <= '0;
         parity_q     <= 1'b0;
         tx_bit_q     <= LINE_IDLE;
         tx_active_q  <= 1'b0;
         in_ready_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         idx_q        <= idx_d;
         parity_q     <= parity_d;
         tx_bit_q     <= tx_bit_d;
         tx_active_q  <= tx_active_d;
         in_ready_q   <= in_ready_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign tx_bit     = tx_bit_q;
   assign tx_active  = tx_active_q;
   assign parity_out = parity_q;
   assign frame_done = frame_done_q;

endmodule : parity_serial_tx
`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_serial_tx
// Description : Directed bench for parity_serial_tx. Three instances: even
//               parity and odd parity with two-cycle bit-times, and even
//               parity with single-cycle bit-times.
// Revision    : 1.0  initial release
// ============================================================================
module tb_parity_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [2:0]      vld;
   logic [2:0][3:0] dat;
   logic [2:0]      rdy, txb, act, par, fd;

   int checks = 0;
   int errors = 0;

   parity_serial_tx #(.DATA_W(4), .BAUD_DIV(2), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_data(dat[0]),
      .in_ready(rdy[0]), .tx_bit(txb[0]), .tx_active(act[0]),
      .parity_out(par[0]), .frame_done(fd[0]));

   parity_serial_tx #(.DATA_W(4), .BAUD_DIV(2), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_data(dat[1]),
      .in_ready(rdy[1]), .tx_bit(txb[1]), .tx_active(act[1]),
      .parity_out(par[1]), .frame_done(fd[1]));

   parity_serial_tx #(.DATA_W(4), .BAUD_DIV(1), .PARITY_ODD(0)) u_fast (
      .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_data(dat[2]),
      .in_ready(rdy[2]), .tx_bit(txb[2]), .tx_active(act[2]),
      .parity_out(par[2]), .frame_done(fd[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for ready, hand over one word; returns at the
   // negedge of the first frame cycle
   task automatic start_frame(input int u, input logic [3:0] data, input bit keep);
      int n = 0;
      while (rdy[u] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_send", 32'(rdy[u]), 32'd1);
      vld[u] = 1'b1;
      dat[u] = data;
      @(posedge clk);
      @(negedge clk);
      if (!keep) vld[u] = 1'b0;
   endtask

   // Record n cycles of line activity; optionally pulse a stray word at cycle inj
   task automatic capture(input int u, input int n, input int inj,
                          output logic [31:0] ln, output int done_at, output int ndone,
                          output int rdy_cnt, output int act_cnt);
      ln = '0; done_at = 0; ndone = 0; rdy_cnt = 0; act_cnt = 0;
      for (int c = 1; c <= n; c++) begin
         ln[c-1] = txb[u];
         if (fd[u] === 1'b1) begin ndone++; done_at = c; end
         if (rdy[u] === 1'b1) rdy_cnt++;
         if (act[u] === 1'b1) act_cnt++;
         if (inj != 0 && c == inj) begin vld[u] = 1'b1; dat[u] = 4'hF; end
         if (inj != 0 && c == inj + 1) vld[u] = 1'b0;
         @(negedge clk);
      end
   endtask

   // Far-end receiver view of a two-cycle-per-bit frame
   function automatic logic [3:0] rx_data(input logic [31:0] ln);
      return {ln[8], ln[6], ln[4], ln[2]};
   endfunction

   logic [31:0] ln;
   int          done_at, ndone, rc, ac, ones, fdc;
   logic [3:0]  s2_data [3] = '{4'b0100, 4'b0011, 4'b0000};
   logic        s2_par  [3] = '{1'b1, 1'b0, 1'b0};
   logic [3:0]  s3_data [2] = '{4'b0001, 4'b1111};
   logic        s3_par  [2] = '{1'b0, 1'b1};

   initial begin
      rst_n = 1'b0;
      vld   = '0;
      dat   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",   32'(rdy[0]), 32'd0);
      chk("rst_tx_bit",     32'(txb[0]), 32'd1);
      chk("rst_tx_active",  32'(act[0]), 32'd0);
      chk("rst_parity",     32'(par[0]), 32'd0);
      chk("rst_frame_done", 32'(fd[0]),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", 32'(rdy[0]), 32'd1);

      // Scenario 1: even parity, 0001
      start_frame(0, 4'b0001, 1'b0);
      capture(0, 14, 0, ln, done_at, ndone, rc, ac);
      chk("s1_line",       ln, 32'h3C0C);
      chk("s1_parity",     32'(par[0]), 32'd1);
      chk("s1_done_cycle", 32'(done_at), 32'd14);
      chk("s1_done_count", 32'(ndone), 32'd1);
      chk("s1_active_len", 32'(ac), 32'd14);
      chk("s1_ready_busy", 32'(rc), 32'd0);
      chk("s1_idle_ready", 32'(rdy[0]), 32'd1);
      chk("s1_idle_line",  32'(txb[0]), 32'd1);
      chk("s1_idle_act",   32'(act[0]), 32'd0);

      // Scenario 2: even parity over several words
      for (int i = 0; i < 3; i++) begin
         start_frame(0, s2_data[i], 1'b0);
         capture(0, 14, 0, ln, done_at, ndone, rc, ac);
         chk("s2_parity", 32'(par[0]), 32'(s2_par[i]));
         chk("s2_data",   32'(rx_data(ln)), 32'(s2_data[i]));
         chk("s2_start",  32'(ln[0]), 32'd0);
         chk("s2_stop",   32'(ln[12]), 32'd1);
         ones = $countones({rx_data(ln), ln[10]});
         chk("s2_even_total", 32'(ones % 2), 32'd0);
      end

      // Scenario 3: odd parity
      for (int i = 0; i < 2; i++) begin
         start_frame(1, s3_data[i], 1'b0);
         capture(1, 14, 0, ln, done_at, ndone, rc, ac);
         chk("s3_parity", 32'(par[1]), 32'(s3_par[i]));
         chk("s3_data",   32'(rx_data(ln)), 32'(s3_data[i]));
         ones = $countones({rx_data(ln), ln[10]});
         chk("s3_odd_total", 32'(ones % 2), 32'd1);
      end

      // Scenario 4: valid held high across two words
      start_frame(0, 4'b1010, 1'b1);
      dat[0] = 4'b0101;
      capture(0, 14, 0, ln, done_at, ndone, rc, ac);
      chk("s4_f1_data",   32'(rx_data(ln)), 32'h A);
      chk("s4_f1_parity", 32'(ln[10]), 32'd0);
      chk("s4_gap_ready", 32'(rdy[0]), 32'd1);
      chk("s4_gap_line",  32'(txb[0]), 32'd1);
      chk("s4_gap_act",   32'(act[0]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      vld[0] = 1'b0;
      chk("s4_f2_start_act",   32'(act[0]), 32'd1);
      chk("s4_f2_start_ready", 32'(rdy[0]), 32'd0);
      capture(0, 14, 0, ln, done_at, ndone, rc, ac);
      chk("s4_f2_data",   32'(rx_data(ln)), 32'h5);
      chk("s4_f2_start",  32'(ln[0]), 32'd0);
      chk("s4_f2_parity", 32'(ln[10]), 32'd0);
      chk("s4_f2_done",   32'(done_at), 32'd14);

      // Scenario 5: stray word while busy is dropped
      start_frame(0, 4'b0001, 1'b0);
      capture(0, 14, 5, ln, done_at, ndone, rc, ac);
      chk("s5_line",       ln, 32'h3C0C);
      chk("s5_ready_busy", 32'(rc), 32'd0);
      chk("s5_done_count", 32'(ndone), 32'd1);
      chk("s5_parity",     32'(par[0]), 32'd1);
      chk("s5_idle_ready", 32'(rdy[0]), 32'd1);
      @(negedge clk);
      chk("s5_no_queued_act",  32'(act[0]), 32'd0);
      chk("s5_no_queued_line", 32'(txb[0]), 32'd1);

      // Scenario 6: reset in the middle of DATA
      start_frame(0, 4'b0011, 1'b0);
      repeat (4) @(negedge clk);
      chk("s6_in_data_act", 32'(act[0]), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("s6_rst_line",   32'(txb[0]), 32'd1);
      chk("s6_rst_act",    32'(act[0]), 32'd0);
      chk("s6_rst_ready",  32'(rdy[0]), 32'd0);
      chk("s6_rst_done",   32'(fd[0]),  32'd0);
      chk("s6_rst_parity", 32'(par[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s6_ready_release", 32'(rdy[0]), 32'd1);
      fdc = 0;
      repeat (20) begin
         if (fd[0] === 1'b1) fdc++;
         @(negedge clk);
      end
      chk("s6_no_done_pulse", 32'(fdc), 32'd0);

      // Single-cycle bit-times: scenario 1 again
      start_frame(2, 4'b0001, 1'b0);
      capture(2, 7, 0, ln, done_at, ndone, rc, ac);
      chk("s7_line",       ln, 32'h62);
      chk("s7_done_cycle", 32'(done_at), 32'd7);
      chk("s7_done_count", 32'(ndone), 32'd1);
      chk("s7_active_len", 32'(ac), 32'd7);
      chk("s7_idle_ready", 32'(rdy[2]), 32'd1);
      chk("s7_idle_act",   32'(act[2]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_parity_serial_tx
`default_nettype wire
